// File: rtl/fetch_align_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_align_ctrl_pkg
// Purpose  : Shared sizes, types and helpers for the fetch/align controller.
// Revision : 1.0 - initial release
// ============================================================================
package fetch_align_ctrl_pkg;

  localparam int LINE_BYTES = 16;
  localparam int BUF_BYTES  = 32;
  localparam int CNT_W      = 6;   // occupancy 0..32
  localparam int IDX_W      = 5;   // byte index 0..31

  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [IDX_W-1:0] idx_t;

  // Byte k of a cache line; address byte 0 lives in the top byte lane.
  function automatic logic [7:0] line_byte(input logic [8*LINE_BYTES-1:0] line,
                                           input logic [3:0] k);
    return line[8*(LINE_BYTES-1-int'(k)) +: 8];
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_rotator.sv
`default_nettype none
// ============================================================================
// Module   : fetch_rotator
// Purpose  : Extracts a 16-byte window starting at a head index from a
//            32-byte circular buffer (wrapping past the last byte).
// Revision : 1.0 - initial release
// ============================================================================
module fetch_rotator
  import fetch_align_ctrl_pkg::*;
(
  input  logic [8*BUF_BYTES-1:0]  buffer,
  input  idx_t                    head,
  output logic [8*LINE_BYTES-1:0] ir
);

  logic [7:0] w_bytes [BUF_BYTES];

  // Buffer byte 0 sits in the most significant lane of the flat vector.
  for (genvar j = 0; j < BUF_BYTES; j++) begin : g_unpack
    assign w_bytes[j] = buffer[8*(BUF_BYTES-1-j) +: 8];
  end

  // Window byte i is buffer byte (head + i) mod 32; 5-bit add wraps for free.
  for (genvar i = 0; i < LINE_BYTES; i++) begin : g_extract
    idx_t w_idx;
    assign w_idx = head + idx_t'(i);
    assign ir[8*(LINE_BYTES-1-i) +: 8] = w_bytes[w_idx];
  end

endmodule
`default_nettype wire

// File: rtl/fetch_align_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fetch_align_ctrl
// Purpose  : Instruction fetch/align buffer. Requests 16-byte lines from the
//            I-cache into a 32-byte circular buffer and presents a 16-byte
//            window at the current EIP to the decoder, which consumes
//            variable-length instructions.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_align_ctrl
  import fetch_align_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_EIP = 32'h0000_0000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    redirect,
  input  logic [31:0]             redirect_eip,
  output logic                    icache_req,
  output logic [31:0]             icache_addr,
  input  logic                    icache_ready,
  input  logic [8*LINE_BYTES-1:0] icache_data,
  output logic [8*LINE_BYTES-1:0] IR,
  output logic                    ir_valid,
  output logic [31:0]             EIP,
  input  logic                    dec_ready,
  input  logic [3:0]              instr_length_updt
);

  cnt_t        r_count;
  idx_t        r_head;
  logic [31:0] r_fetch_addr;
  logic [31:0] r_eip;
  logic [3:0]  r_skip;

  cnt_t        w_fill_len;
  cnt_t        w_space;
  cnt_t        w_len_ext;
  cnt_t        w_count_next;
  idx_t        w_wr_base;
  logic        w_xfer;
  logic        w_consume;
  logic [8*BUF_BYTES-1:0] w_buf_flat;

  // Bytes a line contributes: the first line after a redirect skips the
  // bytes below the target address.
  assign w_fill_len = cnt_t'(LINE_BYTES) - {2'b00, r_skip};
  assign w_space    = cnt_t'(BUF_BYTES) - r_count;
  assign w_len_ext  = {2'b00, instr_length_updt};

  // Only request when the whole useful part of the line is guaranteed to fit,
  // so occupancy can never overflow regardless of simultaneous consumption.
  assign icache_req  = !reset && !redirect && (w_space >= w_fill_len);
  assign icache_addr = r_fetch_addr;
  assign w_xfer      = icache_req && icache_ready;

  assign ir_valid  = (r_count >= cnt_t'(LINE_BYTES));
  assign w_consume = ir_valid && dec_ready && (instr_length_updt != 4'd0);

  assign w_count_next = r_count
                      + (w_xfer    ? w_fill_len : cnt_t'(0))
                      - (w_consume ? w_len_ext  : cnt_t'(0));

  // Incoming bytes land just past the valid region.
  assign w_wr_base = r_head + r_count[IDX_W-1:0];

  assign EIP = r_eip;

  // Control state: occupancy, head, EIP and fetch pointer; redirect overrides
  // any transfer or consume in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count      <= '0;
      r_head       <= '0;
      r_eip        <= RESET_EIP;
      r_fetch_addr <= {RESET_EIP[31:4], 4'b0000};
      r_skip       <= RESET_EIP[3:0];
    end else if (redirect) begin
      r_count      <= '0;
      r_head       <= '0;
      r_eip        <= redirect_eip;
      r_fetch_addr <= {redirect_eip[31:4], 4'b0000};
      r_skip       <= redirect_eip[3:0];
    end else begin
      r_count <= w_count_next;
      if (w_consume) begin
        r_head <= r_head + {1'b0, instr_length_updt};
        r_eip  <= r_eip + {28'd0, instr_length_updt};
      end
      if (w_xfer) begin
        r_fetch_addr <= r_fetch_addr + 32'd16;
        r_skip       <= 4'd0;
      end
    end
  end

  // One register per buffer slot; each slot decides whether this cycle's
  // line covers it and which line byte it takes.
  for (genvar j = 0; j < BUF_BYTES; j++) begin : g_slot
    idx_t       w_off;
    logic       w_hit;
    logic [3:0] w_src;
    logic [7:0] r_byte;

    assign w_off = idx_t'(j) - w_wr_base;
    assign w_hit = w_xfer && ({1'b0, w_off} < w_fill_len);
    assign w_src = w_off[3:0] + r_skip;

    // Data-only storage: contents are meaningless until counted as valid.
    always_ff @(posedge clk) begin
      if (w_hit) begin
        r_byte <= line_byte(icache_data, w_src);
      end
    end

    assign w_buf_flat[8*(BUF_BYTES-1-j) +: 8] = r_byte;
  end

  fetch_rotator u_rotator (
    .buffer (w_buf_flat),
    .head   (r_head),
    .ir     (IR)
  );

endmodule
`default_nettype wire

// File: tb/tb_fetch_align_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_align_ctrl
// Purpose  : Self-checking bench for fetch_align_ctrl: directed vector table,
//            hand-written wrap/reset sequences and randomized traffic against
//            an address-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_align_ctrl;

  localparam logic [31:0] RESET_EIP = 32'h0000_0000;

  logic         clk = 1'b0;
  logic         reset;
  logic         redirect;
  logic [31:0]  redirect_eip;
  logic         icache_req;
  logic [31:0]  icache_addr;
  logic         icache_ready;
  logic [127:0] icache_data;
  logic [127:0] IR;
  logic         ir_valid;
  logic [31:0]  EIP;
  logic         dec_ready;
  logic [3:0]   instr_length_updt;

  int n_checks = 0;
  int n_errors = 0;

  // Model: buffer holds exactly the contiguous bytes [m_eip, m_end).
  logic [31:0] m_eip;
  logic [31:0] m_end;

  fetch_align_ctrl #(.RESET_EIP(RESET_EIP)) dut (
    .clk               (clk),
    .reset             (reset),
    .redirect          (redirect),
    .redirect_eip      (redirect_eip),
    .icache_req        (icache_req),
    .icache_addr       (icache_addr),
    .icache_ready      (icache_ready),
    .icache_data       (icache_data),
    .IR                (IR),
    .ir_valid          (ir_valid),
    .EIP               (EIP),
    .dec_ready         (dec_ready),
    .instr_length_updt (instr_length_updt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic [31:0] re;
    logic        rdy;
    logic        dec;
    logic [3:0]  len;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_eip;
  } vec_t;

  vec_t vecs [12];

  // Memory image: unique-looking byte per address.
  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    logic [7:0] lo;
    lo = a[7:0] * 8'd37;
    return lo ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'hA5;
  endfunction

  function automatic logic [127:0] window(input logic [31:0] a);
    logic [127:0] w;
    for (int k = 0; k < 16; k++) w[127-8*k -: 8] = mem_byte(a + 32'(k));
    return w;
  endfunction

  function automatic logic [31:0] m_line();
    return {m_end[31:4], 4'b0000};
  endfunction

  function automatic logic m_req();
    logic [31:0] c;
    c = m_end - m_eip;
    return !redirect && ((32'd32 - c) >= (32'd16 - {28'd0, m_end[3:0]}));
  endfunction

  function automatic logic m_valid();
    return (m_end - m_eip) >= 32'd16;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rd, input logic [31:0] re, input logic rdy,
                       input logic dec, input logic [3:0] len);
    @(negedge clk);
    redirect          = rd;
    redirect_eip      = re;
    icache_ready      = rdy;
    dec_ready         = dec;
    instr_length_updt = len;
    icache_data       = window(m_line());
    #1;
  endtask

  task automatic model_check();
    chk("icache_req",  128'(icache_req),  128'(m_req()));
    chk("icache_addr", 128'(icache_addr), 128'(m_line()));
    chk("ir_valid",    128'(ir_valid),    128'(m_valid()));
    chk("EIP",         128'(EIP),         128'(m_eip));
    if (m_valid()) chk("IR", IR, window(m_eip));
  endtask

  task automatic advance();
    logic xfer;
    logic cons;
    @(posedge clk);
    xfer = m_req() && icache_ready;
    cons = m_valid() && dec_ready && (instr_length_updt != 4'd0);
    if (redirect) begin
      m_eip = redirect_eip;
      m_end = redirect_eip;
    end else begin
      if (xfer) m_end = m_line() + 32'd16;
      if (cons) m_eip = m_eip + {28'd0, instr_length_updt};
    end
  endtask

  task automatic step(input logic rd, input logic [31:0] re, input logic rdy,
                      input logic dec, input logic [3:0] len);
    drive(rd, re, rdy, dec, len);
    model_check();
    advance();
  endtask

  // Stimulus and checking.
  initial begin
    vecs[0]  = '{1'b0, 32'h0,      1'b1, 1'b0, 4'd0, 1'b1, 32'h0000_0000, 1'b0, 32'h0000_0000};
    vecs[1]  = '{1'b0, 32'h0,      1'b0, 1'b0, 4'd0, 1'b1, 32'h0000_0010, 1'b1, 32'h0000_0000};
    vecs[2]  = '{1'b0, 32'h0,      1'b1, 1'b1, 4'd3, 1'b1, 32'h0000_0010, 1'b1, 32'h0000_0000};
    vecs[3]  = '{1'b0, 32'h0,      1'b1, 1'b0, 4'd0, 1'b0, 32'h0000_0020, 1'b1, 32'h0000_0003};
    vecs[4]  = '{1'b1, 32'h1007,   1'b1, 1'b0, 4'd0, 1'b0, 32'h0000_0020, 1'b1, 32'h0000_0003};
    vecs[5]  = '{1'b0, 32'h0,      1'b1, 1'b0, 4'd0, 1'b1, 32'h0000_1000, 1'b0, 32'h0000_1007};
    vecs[6]  = '{1'b0, 32'h0,      1'b0, 1'b0, 4'd0, 1'b1, 32'h0000_1010, 1'b0, 32'h0000_1007};
    vecs[7]  = '{1'b0, 32'h0,      1'b1, 1'b0, 4'd0, 1'b1, 32'h0000_1010, 1'b0, 32'h0000_1007};
    vecs[8]  = '{1'b0, 32'h0,      1'b0, 1'b1, 4'd5, 1'b0, 32'h0000_1020, 1'b1, 32'h0000_1007};
    vecs[9]  = '{1'b0, 32'h0,      1'b0, 1'b1, 4'd0, 1'b0, 32'h0000_1020, 1'b1, 32'h0000_100C};
    vecs[10] = '{1'b1, 32'h2000,   1'b1, 1'b1, 4'd4, 1'b0, 32'h0000_1020, 1'b1, 32'h0000_100C};
    vecs[11] = '{1'b0, 32'h0,      1'b0, 1'b0, 4'd0, 1'b1, 32'h0000_2000, 1'b0, 32'h0000_2000};

    reset = 1'b1; redirect = 1'b0; redirect_eip = '0; icache_ready = 1'b0;
    icache_data = '0; dec_ready = 1'b0; instr_length_updt = '0;
    m_eip = RESET_EIP; m_end = RESET_EIP;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req",   128'(icache_req),  128'(1'b0));
    chk("rst_valid", 128'(ir_valid),    128'(1'b0));
    chk("rst_eip",   128'(EIP),         128'(RESET_EIP));
    chk("rst_addr",  128'(icache_addr), 128'({RESET_EIP[31:4], 4'b0000}));
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("req_after_reset", 128'(icache_req), 128'(1'b1));

    // Directed table
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].rd, vecs[i].re, vecs[i].rdy, vecs[i].dec, vecs[i].len);
      chk($sformatf("vec%0d_req", i),   128'(icache_req),  128'(vecs[i].e_req));
      chk($sformatf("vec%0d_addr", i),  128'(icache_addr), 128'(vecs[i].e_addr));
      chk($sformatf("vec%0d_valid", i), 128'(ir_valid),    128'(vecs[i].e_valid));
      chk($sformatf("vec%0d_eip", i),   128'(EIP),         128'(vecs[i].e_eip));
      if (i == 8) chk("vec8_ir_head", 128'(IR[127:120]), 128'(mem_byte(32'h1007)));
      model_check();
      advance();
    end

    // EIP and fetch address wrap at the top of the address space
    step(1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 4'd0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 4'd0);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 4'd0);
    chk("wrap_fetch_addr", 128'(icache_addr), 128'(32'h0));
    model_check();
    advance();
    step(1'b0, 32'h0, 1'b0, 1'b1, 4'd4);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 4'd0);
    chk("wrap_eip", 128'(EIP), 128'(32'h0000_0002));
    model_check();
    advance();

    // Head index wrapping past the end of the circular buffer
    step(1'b1, 32'h3000, 1'b0, 1'b0, 4'd0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 4'd0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 4'd0);
    step(1'b0, 32'h0, 1'b0, 1'b1, 4'd15);
    step(1'b0, 32'h0, 1'b0, 1'b1, 4'd15);
    step(1'b0, 32'h0, 1'b1, 1'b0, 4'd0);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 4'd0);
    chk("head30_ir", IR, window(32'h301E));
    model_check();
    advance();
    step(1'b0, 32'h0, 1'b0, 1'b1, 4'd5);
    step(1'b0, 32'h0, 1'b1, 1'b0, 4'd0);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 4'd0);
    chk("head3_eip", 128'(EIP), 128'(32'h3023));
    chk("head3_ir",  IR, window(32'h3023));
    model_check();
    advance();

    // Reset asserted during a line transfer
    drive(1'b0, 32'h0, 1'b1, 1'b0, 4'd0);
    reset = 1'b1;
    #1;
    chk("midrst_req",   128'(icache_req),  128'(1'b0));
    chk("midrst_valid", 128'(ir_valid),    128'(1'b0));
    chk("midrst_eip",   128'(EIP),         128'(RESET_EIP));
    chk("midrst_addr",  128'(icache_addr), 128'({RESET_EIP[31:4], 4'b0000}));
    @(negedge clk);
    reset = 1'b0;
    icache_ready = 1'b0;
    m_eip = RESET_EIP; m_end = RESET_EIP;
    #1;
    chk("midrst_req_after", 128'(icache_req), 128'(1'b1));

    // Randomized traffic
    for (int n = 0; n < 4000; n++) begin
      logic        rd;
      logic [31:0] re;
      rd = ($urandom % 16) == 0;
      re = (($urandom % 4) == 0) ? (32'hFFFF_FFF0 | ($urandom % 16)) : $urandom;
      step(rd, re, ($urandom % 10) < 7, ($urandom % 10) < 6, 4'($urandom % 16));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
